// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the XOR-sharing arbiter.
package xor_arb_pkg;
   localparam int WORD_W    = 4;
   localparam int N_REQ_MAX = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/exor_gate_4b.sv
// 4-bit bitwise XOR gate, the shared datapath.
module exor_gate_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);
   assign y = a ^ b;
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr+1, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  win_idx,
   output logic [N_REQ-1:0] win_onehot,
   output logic             any
);
   // Scan from the farthest offset down to ptr+1 so the nearest hit is written last.
   always_comb begin
      int j;
      logic [ID_W-1:0] idx;
      win_idx    = '0;
      win_onehot = '0;
      any        = 1'b0;
      for (int i = N_REQ; i >= 1; i--) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         idx = ID_W'(j);
         if (req[idx]) begin
            win_idx = idx;
            any     = 1'b1;
         end
      end
      if (any) win_onehot[win_idx] = 1'b1;
   end
endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin sharing of one exor_gate_4b among N_REQ requesters.
// IDLE grants and latches operands, CALC registers the result, HOLD waits for y_ready.
module xor_share_arbiter
   import xor_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req,
   input  logic [WORD_W*N_REQ-1:0] a_in,
   input  logic [WORD_W*N_REQ-1:0] b_in,
   output logic [N_REQ-1:0]      gnt,
   output logic [WORD_W-1:0]     y_out,
   output logic [ID_W-1:0]       y_id,
   output logic                  y_valid,
   input  logic                  y_ready,
   output logic                  busy
);
   state_t              state, state_nxt;
   logic [ID_W-1:0]     ptr;
   logic [WORD_W-1:0]   op_a, op_b, xor_y;
   logic [ID_W-1:0]     win_idx;
   logic [N_REQ-1:0]    win_onehot;
   logic                any;
   logic                ld_op, ld_res, clr_vld;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req        (req),
      .ptr        (ptr),
      .win_idx    (win_idx),
      .win_onehot (win_onehot),
      .any        (any)
   );

   exor_gate_4b u_xor (
      .a (op_a),
      .b (op_b),
      .y (xor_y)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and register-load strobes; req is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      ld_op     = 1'b0;
      ld_res    = 1'b0;
      clr_vld   = 1'b0;
      case (state)
         IDLE: if (any) begin
            state_nxt = CALC;
            ld_op     = 1'b1;
         end
         CALC: begin
            state_nxt = HOLD;
            ld_res    = 1'b1;
         end
         HOLD: if (y_ready) begin
            state_nxt = IDLE;
            clr_vld   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant pulse, operand capture and pointer advance; ptr resets to the last
   // index so requester 0 is favoured first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt  <= '0;
         op_a <= '0;
         op_b <= '0;
         ptr  <= ID_W'(N_REQ - 1);
      end else begin
         gnt <= ld_op ? win_onehot : '0;
         if (ld_op) begin
            op_a <= a_in[win_idx*WORD_W +: WORD_W];
            op_b <= b_in[win_idx*WORD_W +: WORD_W];
            ptr  <= win_idx;
         end
      end
   end

   // Result registers, held stable in HOLD until the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_out   <= '0;
         y_id    <= '0;
         y_valid <= 1'b0;
      end else if (ld_res) begin
         y_out   <= xor_y;
         y_id    <= ptr;
         y_valid <= 1'b1;
      end else if (clr_vld) begin
         y_valid <= 1'b0;
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench with a result scoreboard for xor_share_arbiter.
module tb_xor_share_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] a_in, b_in;
   logic [3:0]  gnt;
   logic [3:0]  y_out;
   logic [1:0]  y_id;
   logic        y_valid, y_ready, busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] y;
   } exp_t;
   exp_t sb[$];

   xor_share_arbiter #(.N_REQ(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .a_in    (a_in),
      .b_in    (b_in),
      .gnt     (gnt),
      .y_out   (y_out),
      .y_id    (y_id),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .busy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      a_in[4*i +: 4] = a;
      b_in[4*i +: 4] = b;
   endtask

   task automatic push(input logic [1:0] id, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      e.id = id;
      e.y  = a ^ b;
      sb.push_back(e);
   endtask

   // Bounded wait for a grant, then compare it.
   task automatic wait_gnt(input logic [3:0] exp, input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (gnt == 4'd0 && n < 12);
      chk(tag, gnt, exp);
   endtask

   // Scoreboard check at every completed transfer, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && y_valid && y_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_unexpected observed id=%0d y=%0h expected=none", y_id, y_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("y_id", 32'(y_id), 32'(e.id));
            chk("y_out", 32'(y_out), 32'(e.y));
         end
      end
   end

   initial begin
      int prev;
      rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; y_ready = 1'b0;
      #12;
      // reset state
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_y_out", 32'(y_out), 0);
      chk("rst_y_id", 32'(y_id), 0);
      chk("rst_y_valid", 32'(y_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      step();
      rst_n = 1'b1;

      // single requester
      y_ready = 1'b1;
      set_op(0, 4'b1010, 4'b0101);
      push(0, 4'b1010, 4'b0101);
      req = 4'b0001;
      step();
      chk("single_gnt", 32'(gnt), 32'b0001);
      chk("single_busy", 32'(busy), 1);
      req = 4'b0000;
      step();
      chk("single_gnt_off", 32'(gnt), 0);
      chk("single_valid", 32'(y_valid), 1);
      chk("single_y", 32'(y_out), 32'hF);
      step();
      chk("single_valid_off", 32'(y_valid), 0);
      chk("single_busy_off", 32'(busy), 0);

      // all four, one op each, from a fresh pointer
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      set_op(0, 4'b1111, 4'b0000);
      set_op(1, 4'b1100, 4'b0011);
      set_op(2, 4'b1010, 4'b1000);
      set_op(3, 4'b1001, 4'b1001);
      push(0, 4'b1111, 4'b0000);
      push(1, 4'b1100, 4'b0011);
      push(2, 4'b1010, 4'b1000);
      push(3, 4'b1001, 4'b1001);
      req = 4'b1111;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(4'(1 << i), "all_gnt");
         if (i > 0) chk("all_spacing", 32'(cyc - prev), 3);
         prev = cyc;
         req[i] = 1'b0;
      end
      step(); step(); step();

      // backpressure
      y_ready = 1'b0;
      set_op(2, 4'b0110, 4'b0011);
      push(2, 4'b0110, 4'b0011);
      req = 4'b0100;
      wait_gnt(4'b0100, "bp_gnt");
      req = 4'b0000;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(y_valid), 1);
         chk("bp_y", 32'(y_out), 32'h5);
         chk("bp_id", 32'(y_id), 2);
         chk("bp_gnt", 32'(gnt), 0);
         chk("bp_busy", 32'(busy), 1);
         step();
      end
      y_ready = 1'b1;
      step();
      chk("bp_release", 32'(y_valid), 0);

      // fairness: 0 and 2 held high, pointer currently at 2
      set_op(0, 4'b0011, 4'b0001);
      push(0, 4'b0011, 4'b0001);
      push(2, 4'b0110, 4'b0011);
      push(0, 4'b0011, 4'b0001);
      push(2, 4'b0110, 4'b0011);
      req = 4'b0101;
      wait_gnt(4'b0001, "fair_gnt0");
      wait_gnt(4'b0100, "fair_gnt1");
      wait_gnt(4'b0001, "fair_gnt2");
      wait_gnt(4'b0100, "fair_gnt3");
      req = 4'b0000;
      step(); step(); step();

      // glitch on req1 during CALC only
      set_op(3, 4'b1110, 4'b0100);
      push(3, 4'b1110, 4'b0100);
      req = 4'b1000;
      wait_gnt(4'b1000, "glitch_gnt3");
      req = 4'b0010;
      step();
      req = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         chk("glitch_no_gnt", 32'(gnt), 0);
         step();
      end
      chk("glitch_idle", 32'(busy), 0);

      // reset mid-HOLD discards the result
      y_ready = 1'b0;
      set_op(0, 4'b0111, 4'b0001);
      req = 4'b0001;
      wait_gnt(4'b0001, "rsth_gnt");
      req = 4'b0000;
      step();
      chk("rsth_valid", 32'(y_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rsth_y_valid", 32'(y_valid), 0);
      chk("rsth_y_out", 32'(y_out), 0);
      chk("rsth_busy", 32'(busy), 0);
      chk("rsth_gnt", 32'(gnt), 0);
      step();
      chk("rsth_no_regnt", 32'(gnt), 0);
      y_ready = 1'b1;
      rst_n = 1'b1;
      set_op(1, 4'b0101, 4'b0110);
      push(1, 4'b0101, 4'b0110);
      req = 4'b0010;
      wait_gnt(4'b0010, "rsth_first_gnt");
      req = 4'b0000;
      step(); step(); step();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
